// File: rtl/jtag_ping_pong_buffer.sv
// Two-bank ping-pong word buffer feeding the JTAG data-register chain.
// A producer fills one bank while the chain drains the other, all on JTCK.
module jtag_ping_pong_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                  JTCK,
  input  logic                  JRSTN,
  input  logic                  clear,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_last,
  output logic                  wr_ready,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] pp_dataOut,
  output logic                  switch_ready,
  output logic                  rd_last,
  output logic [1:0]            bank_full,
  output logic                  underflow
);

  localparam int               IDX_W   = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W:0]   CNT_ONE = {{IDX_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FILLING,
    ST_FULL
  } bank_state_e;

  bank_state_e           state_q [2];
  bank_state_e           state_d [2];
  logic [IDX_W:0]        count_q [2];
  logic [IDX_W:0]        count_d [2];
  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0]      wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]      rd_idx_q, rd_idx_d;
  logic                  underflow_q, underflow_d;
  logic [DATA_WIDTH-1:0] mem_q [2][DEPTH];

  logic wr_fire;
  logic wr_commit;
  logic rd_fire;

  assign wr_ready     = (state_q[wr_bank_q] != ST_FULL);
  assign switch_ready = (state_q[rd_bank_q] == ST_FULL);
  assign rd_last      = switch_ready && (({1'b0, rd_idx_q} + CNT_ONE) == count_q[rd_bank_q]);
  assign pp_dataOut   = switch_ready ? mem_q[rd_bank_q][rd_idx_q] : '0;
  assign bank_full    = {state_q[1] == ST_FULL, state_q[0] == ST_FULL};
  assign underflow    = underflow_q;

  assign wr_fire   = wr_valid && wr_ready;
  assign wr_commit = wr_fire && (wr_last || (wr_idx_q == IDX_MAX));
  assign rd_fire   = rd_en && switch_ready;

  // Writer and reader always address different banks (one FULL, one not),
  // so their updates below never collide.
  always_comb begin
    // NOTE: every next-state signal is defaulted to its current value first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    count_d     = count_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    underflow_d = underflow_q;

    if (wr_fire) begin
      if (wr_commit) begin
        state_d[wr_bank_q] = ST_FULL;
        count_d[wr_bank_q] = {1'b0, wr_idx_q} + CNT_ONE;
        wr_bank_d          = ~wr_bank_q;
        wr_idx_d           = '0;
      end else begin
        state_d[wr_bank_q] = ST_FILLING;
        wr_idx_d           = wr_idx_q + 1'b1;
      end
    end

    if (rd_fire) begin
      if (rd_last) begin
        state_d[rd_bank_q] = ST_EMPTY;
        count_d[rd_bank_q] = '0;
        rd_bank_d          = ~rd_bank_q;
        rd_idx_d           = '0;
      end else begin
        rd_idx_d = rd_idx_q + 1'b1;
      end
    end else if (rd_en) begin
      underflow_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge JTCK) begin
    if (!JRSTN || clear) begin
      state_q     <= '{default: ST_EMPTY};
      count_q     <= '{default: '0};
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: word storage is deliberately not reset; bank state alone decides what is readable.
  always_ff @(posedge JTCK) begin
    if (wr_fire) begin
      mem_q[wr_bank_q][wr_idx_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_jtag_ping_pong_buffer.sv
// Scoreboard bench for jtag_ping_pong_buffer: accepted words are queued with
// their expected rd_last flag and compared against each chain pop.
module tb_jtag_ping_pong_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  // {wr_ready, switch_ready, pp_dataOut, rd_last, bank_full, underflow}
  localparam logic [37:0] RST_OUT = {1'b1, 1'b0, 32'h0, 1'b0, 2'b00, 1'b0};

  logic          JTCK = 1'b0;
  logic          JRSTN;
  logic          clear;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_last;
  logic          wr_ready;
  logic          rd_en;
  logic [DW-1:0] pp_dataOut;
  logic          switch_ready;
  logic          rd_last;
  logic [1:0]    bank_full;
  logic          underflow;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  int   tb_widx = 0;
  int   total   = 0;
  int   bad     = 0;

  jtag_ping_pong_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .JTCK         (JTCK),
    .JRSTN        (JRSTN),
    .clear        (clear),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .wr_last      (wr_last),
    .wr_ready     (wr_ready),
    .rd_en        (rd_en),
    .pp_dataOut   (pp_dataOut),
    .switch_ready (switch_ready),
    .rd_last      (rd_last),
    .bank_full    (bank_full),
    .underflow    (underflow)
  );

  always #5 JTCK = ~JTCK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  // One clock: drive inputs, push accepted writes, compare pops, then step the edge.
  task automatic cycle(input logic wv, input logic [DW-1:0] wd, input logic wl,
                       input logic re, output logic acc);
    exp_t e;
    wr_valid = wv;
    wr_data  = wd;
    wr_last  = wl;
    rd_en    = re;
    #1;
    acc = wv && wr_ready;
    if (acc) begin
      e.data = wd;
      e.last = wl || (tb_widx == DEPTH - 1);
      exp_q.push_back(e);
      tb_widx = e.last ? 0 : tb_widx + 1;
    end
    if (re) begin
      total++;
      if (switch_ready !== 1'b1 || exp_q.size() == 0) begin
        bad++;
        $display("FAIL pop_ready: switch_ready=%b queued=%0d, want ready with data", switch_ready, exp_q.size());
      end else begin
        e = exp_q.pop_front();
        total++;
        if ({pp_dataOut, rd_last} !== {e.data, e.last}) begin
          bad++;
          $display("FAIL pop_data: got %h last=%b, want %h last=%b", pp_dataOut, rd_last, e.data, e.last);
        end
      end
    end
    @(posedge JTCK);
    #1;
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    rd_en    = 1'b0;
  endtask

  task automatic do_reset();
    JRSTN    = 1'b0;
    clear    = 1'b0;
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    wr_data  = '0;
    rd_en    = 1'b0;
    @(posedge JTCK);
    #1;
    JRSTN = 1'b1;
    exp_q.delete();
    tb_widx = 0;
  endtask

  task automatic test_reset();
    logic acc;
    do_reset();
    total++;
    if ({wr_ready, switch_ready, pp_dataOut, rd_last, bank_full, underflow} !== RST_OUT) begin
      bad++;
      $display("FAIL reset_state: got %h, want %h",
               {wr_ready, switch_ready, pp_dataOut, rd_last, bank_full, underflow}, RST_OUT);
    end
    cycle(1'b0, '0, 1'b0, 1'b0, acc);
    total++;
    if ({wr_ready, switch_ready, pp_dataOut, rd_last, bank_full, underflow} !== RST_OUT) begin
      bad++;
      $display("FAIL reset_idle: got %h, want %h",
               {wr_ready, switch_ready, pp_dataOut, rd_last, bank_full, underflow}, RST_OUT);
    end
  endtask

  task automatic test_short_burst();
    logic acc;
    do_reset();
    cycle(1'b1, 32'h11111111, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'h22222222, 1'b0, 1'b0, acc);
    total++;
    if (switch_ready !== 1'b0) begin
      bad++;
      $display("FAIL filling_not_readable: switch_ready=%b, want 0", switch_ready);
    end
    cycle(1'b1, 32'h33333333, 1'b1, 1'b0, acc);
    total++;
    if ({switch_ready, pp_dataOut, bank_full} !== {1'b1, 32'h11111111, 2'b01}) begin
      bad++;
      $display("FAIL burst_commit: ready=%b data=%h full=%b, want 1 11111111 01",
               switch_ready, pp_dataOut, bank_full);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b1, acc);
    total++;
    if ({switch_ready, bank_full} !== 3'b000) begin
      bad++;
      $display("FAIL burst_drained: ready=%b full=%b, want 0 00", switch_ready, bank_full);
    end
  endtask

  task automatic test_stream();
    logic acc;
    int   n;
    do_reset();
    n = 0;
    for (int i = 0; i < 2 * DEPTH; i++) begin
      cycle(1'b1, DW'(i), 1'b0, 1'b0, acc);
      if (acc) n++;
    end
    total++;
    if (n != 2 * DEPTH) begin
      bad++;
      $display("FAIL stream_accept: accepted %0d, want %0d", n, 2 * DEPTH);
    end
    total++;
    if ({bank_full, wr_ready} !== 3'b110) begin
      bad++;
      $display("FAIL stream_full: full=%b wr_ready=%b, want 11 0", bank_full, wr_ready);
    end
    n = 0;
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 32'd32, 1'b0, 1'b1, acc);
      if (acc) n++;
    end
    total++;
    if (n != 0) begin
      bad++;
      $display("FAIL stream_hold: accepted %0d while full, want 0", n);
    end
    total++;
    if (wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL stream_freed: wr_ready=%b, want 1", wr_ready);
    end
    cycle(1'b1, 32'd32, 1'b0, 1'b0, acc);
    total++;
    if (acc !== 1'b1) begin
      bad++;
      $display("FAIL stream_held_word: accepted=%b, want 1", acc);
    end
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b0, 1'b1, acc);
    total++;
    if ({switch_ready, bank_full, wr_ready} !== 4'b0001) begin
      bad++;
      $display("FAIL stream_partial: ready=%b full=%b wr_ready=%b, want 0 00 1",
               switch_ready, bank_full, wr_ready);
    end
    cycle(1'b1, 32'd33, 1'b1, 1'b0, acc);
    cycle(1'b0, '0, 1'b0, 1'b1, acc);
    cycle(1'b0, '0, 1'b0, 1'b1, acc);
    total++;
    if (switch_ready !== 1'b0) begin
      bad++;
      $display("FAIL stream_end: switch_ready=%b, want 0", switch_ready);
    end
  endtask

  task automatic test_ping_pong();
    logic acc;
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'hA0 + DW'(i), (i == 3), 1'b0, acc);
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'hB0 + DW'(i), (i == 3), 1'b1, acc);
    total++;
    if ({switch_ready, pp_dataOut, bank_full} !== {1'b1, 32'hB0, 2'b10}) begin
      bad++;
      $display("FAIL pingpong_switch: ready=%b data=%h full=%b, want 1 000000b0 10",
               switch_ready, pp_dataOut, bank_full);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b1, acc);
    total++;
    if ({switch_ready, bank_full, exp_q.size() == 0} !== 4'b0001) begin
      bad++;
      $display("FAIL pingpong_end: ready=%b full=%b left=%0d, want 0 00 0",
               switch_ready, bank_full, exp_q.size());
    end
  endtask

  task automatic test_underflow();
    logic acc;
    do_reset();
    rd_en = 1'b1;
    @(posedge JTCK);
    #1;
    rd_en = 1'b0;
    total++;
    if ({wr_ready, switch_ready, pp_dataOut, rd_last, bank_full, underflow} !== (RST_OUT | 38'h1)) begin
      bad++;
      $display("FAIL underflow_set: got %h, want %h",
               {wr_ready, switch_ready, pp_dataOut, rd_last, bank_full, underflow}, RST_OUT | 38'h1);
    end
    cycle(1'b0, '0, 1'b0, 1'b0, acc);
    total++;
    if (underflow !== 1'b1) begin
      bad++;
      $display("FAIL underflow_sticky: underflow=%b, want 1", underflow);
    end
    clear = 1'b1;
    @(posedge JTCK);
    #1;
    clear = 1'b0;
    total++;
    if (underflow !== 1'b0) begin
      bad++;
      $display("FAIL underflow_clear: underflow=%b, want 0", underflow);
    end
  endtask

  task automatic test_clear_reset();
    logic acc;
    do_reset();
    cycle(1'b1, 32'hC0, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'hC1, 1'b0, 1'b0, acc);
    clear = 1'b1;
    @(posedge JTCK);
    #1;
    clear = 1'b0;
    exp_q.delete();
    tb_widx = 0;
    total++;
    if ({wr_ready, switch_ready, pp_dataOut, rd_last, bank_full, underflow} !== RST_OUT) begin
      bad++;
      $display("FAIL clear_midfill: got %h, want %h",
               {wr_ready, switch_ready, pp_dataOut, rd_last, bank_full, underflow}, RST_OUT);
    end
    rd_en = 1'b1;
    @(posedge JTCK);
    #1;
    rd_en = 1'b0;
    total++;
    if ({switch_ready, underflow} !== 2'b01) begin
      bad++;
      $display("FAIL clear_discard: ready=%b underflow=%b, want 0 1", switch_ready, underflow);
    end
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'hD0 + DW'(i), (i == 3), 1'b0, acc);
    cycle(1'b0, '0, 1'b0, 1'b1, acc);
    cycle(1'b0, '0, 1'b0, 1'b1, acc);
    JRSTN = 1'b0;
    @(posedge JTCK);
    #1;
    JRSTN = 1'b1;
    exp_q.delete();
    tb_widx = 0;
    total++;
    if ({wr_ready, switch_ready, pp_dataOut, rd_last, bank_full, underflow} !== RST_OUT) begin
      bad++;
      $display("FAIL reset_middrain: got %h, want %h",
               {wr_ready, switch_ready, pp_dataOut, rd_last, bank_full, underflow}, RST_OUT);
    end
  endtask

  initial begin
    JRSTN    = 1'b0;
    clear    = 1'b0;
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    wr_data  = '0;
    rd_en    = 1'b0;
    @(posedge JTCK);
    #1;
    test_reset();
    test_short_burst();
    test_stream();
    test_ping_pong();
    test_underflow();
    test_clear_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jtag_ping_pong_buffer.md
Name: jtag_ping_pong_buffer

Overview:
- Two-bank (ping-pong) word buffer in the JTCK domain. It sits directly upstream of the JTAG data-register chain.
- An already-synchronised bus-side producer fills one bank while the chain drains the other.
- It supplies the chain's `pp_dataOut` word and `switch_ready` flag, and advances one word per chain pop.

Parameters:
- `DATA_WIDTH`, 32, width of one buffered word.
- `DEPTH`, 16, words per bank; must be a power of two, minimum 2.
- `IDX_W`, $clog2(DEPTH), word index width; derived, not overridden.

Ports:
- `JTCK` in 1: single clock; all state updates on rising edge.
- `JRSTN` in 1: reset, synchronous, active-low.
- `clear` in 1: synchronous flush, active-high; same effect as reset, lower priority.
- `wr_valid` in 1: producer word valid.
- `wr_data` in DATA_WIDTH: producer word.
- `wr_last` in 1: word closes the current burst; qualified by `wr_valid`.
- `wr_ready` out 1: buffer can accept a word this cycle.
- `rd_en` in 1: chain pop request, one word per cycle high.
- `pp_dataOut` out DATA_WIDTH: head word of the readable bank.
- `switch_ready` out 1: a committed bank is readable.
- `rd_last` out 1: head word is the last word of its bank.
- `bank_full` out 2: per-bank committed flag, bit0 = bank A, bit1 = bank B.
- `underflow` out 1: sticky; set by a pop while nothing is readable.

Behaviour:
- Storage:
  - 2 x DEPTH flops, not reset.
  - Per bank: state EMPTY / FILLING / FULL, plus a count register of IDX_W+1 bits, range 1..DEPTH.
- Reset (`JRSTN`=0) or `clear`=1:
  - Both banks EMPTY, counts 0.
  - `wr_bank`=A, `rd_bank`=A, `wr_idx`=0, `rd_idx`=0, `underflow`=0.
  - Resulting outputs: `wr_ready`=1, `switch_ready`=0, `pp_dataOut`=0, `rd_last`=0, `bank_full`=00.
- Write side:
  - `wr_ready` = state[wr_bank] is EMPTY or FILLING (combinational).
  - Accept on `wr_valid` & `wr_ready`:
    - mem[wr_bank][wr_idx] <= `wr_data`; EMPTY becomes FILLING.
    - If `wr_last`, or `wr_idx` = DEPTH-1, commit the bank.
    - Commit sets count = `wr_idx`+1 and state = FULL, toggles `wr_bank`, and sets `wr_idx` = 0.
    - Otherwise `wr_idx`++.
  - `wr_valid` without `wr_ready`: no write. The producer holds its word (standard valid/ready).
  - A FILLING bank with no `wr_last` stays FILLING indefinitely and is not readable.
- Read side:
  - `switch_ready` = state[rd_bank] is FULL.
  - `pp_dataOut` = mem[rd_bank][rd_idx] when `switch_ready`, else 0.
  - `rd_last` = `switch_ready` & (`rd_idx` = count[rd_bank]-1).
  - Pop on `rd_en` & `switch_ready`:
    - If `rd_last`: bank becomes EMPTY, count 0, `rd_bank` toggles, `rd_idx` = 0.
    - Otherwise `rd_idx`++.
  - The new head is visible the cycle after the pop edge.
  - `rd_en` while `switch_ready`=0: no state change; `underflow` <= 1. It stays 1 until reset or `clear`.
- Latency:
  - A committing write on edge N makes that bank readable from cycle N+1, provided `rd_bank` points at it.
  - No same-cycle write-to-read bypass.
- `bank_full[b]` = state[b] is FULL.
- Simultaneous events:
  - Commit of one bank and release of the other in the same cycle: both take effect, so the freed bank is writable next cycle.
  - Pop and write target different banks by construction; no conflict.
  - Both banks FULL: `wr_ready`=0 until the reader frees `rd_bank`. Only one pop per cycle.
- Wrap-around: bank toggles alternate A, B, A, ... The index never exceeds DEPTH-1.
- Reset or `clear` mid-burst: partial data is discarded, and pops afterward count as underflow.

Test Plan:
- Reset then idle: `wr_ready`=1, `switch_ready`=0, `pp_dataOut`=0, `bank_full`=00, `underflow`=0.
- Write 3 words 0x11111111, 0x22222222, 0x33333333 with `wr_last` on the third:
  - One cycle later `switch_ready`=1 and `pp_dataOut`=0x11111111.
  - 3 pops return those words in order; `rd_last`=1 on 0x33333333.
  - Then `switch_ready`=0 and `bank_full`=00.
- Stream 2*DEPTH words 0..31 with no `wr_last` and no pops:
  - Both banks commit at 16 words; `bank_full`=11 and `wr_ready`=0.
  - The 33rd word is held.
  - After draining bank A, `wr_ready`=1 and the held word lands at A[0].
- Ping-pong: write bank A (4 words); pop A while writing bank B (4 words). After A's last pop, `pp_dataOut` shows B[0] with no gap.
- Pop on empty: `rd_en` pulse with `switch_ready`=0 sets `underflow`=1 and changes no other output. A later `clear` returns it to 0.
- `clear` asserted mid-fill (2 of 4 words written) then `JRSTN` low mid-drain: all outputs return to their reset values the next cycle.
